// File: rtl/aes_enc_word_loader_pkg.sv
// Shared types and constants for the AES job loader: FSM encoding, word geometry, word indices.
// Pure declarations; no timing or handshake of its own.
package aes_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  localparam int          WORD_W  = 64;
  localparam int          N_WORDS = 7;
  localparam logic [31:0] HDR_LEN = 32'd6;

  localparam logic [2:0] IDX_HDR  = 3'd0;
  localparam logic [2:0] IDX_KEY0 = 3'd1;
  localparam logic [2:0] IDX_PT0  = 3'd5;
  localparam logic [2:0] IDX_LAST = 3'(N_WORDS - 1);

  // Header: marker, job tag, reserved zeros, count of payload words that follow.
  function automatic logic [WORD_W-1:0] hdr_word(input logic [7:0] magic, input logic [7:0] tag);
    return {magic, tag, 16'h0000, HDR_LEN};
  endfunction

endpackage

// File: rtl/aes_enc_word_loader_if.sv
// Word write port into the AES core export input; a word moves when wr_valid=1 and wr_waitrequest=0.
// Master holds wr_data stable while the slave asserts wr_waitrequest.
interface aes_enc_word_loader_if;
  import aes_loader_pkg::*;

  logic [WORD_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_waitrequest;

  modport master (
    output wr_data,
    output wr_valid,
    input  wr_waitrequest
  );

  modport slave (
    input  wr_data,
    input  wr_valid,
    output wr_waitrequest
  );

endinterface

// File: rtl/aes_enc_word_loader_word_mux.sv
// Combinational 7:1 word selector: header, four key words (MSW first), two plaintext words.
// Zero latency; no handshake, the caller decides when the selected word is captured.
module aes_loader_word_mux
  import aes_loader_pkg::*;
#(
  parameter logic [7:0] MAGIC = 8'hA5
) (
  input  logic [2:0]        idx,
  input  logic [255:0]      key,
  input  logic [127:0]      plaintext,
  input  logic [7:0]        tag,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    word = '0;
    case (idx)
      IDX_HDR:           word = hdr_word(MAGIC, tag);
      IDX_KEY0:          word = key[255:192];
      IDX_KEY0 + 3'd1:   word = key[191:128];
      IDX_KEY0 + 3'd2:   word = key[127:64];
      IDX_KEY0 + 3'd3:   word = key[63:0];
      IDX_PT0:           word = plaintext[127:64];
      IDX_LAST:          word = plaintext[63:0];
      default:           word = '0;
    endcase
  end

endmodule

// File: rtl/aes_enc_word_loader.sv
// Latches key/plaintext on start and streams 7 registered words (header first) to the AES core, then waits for core_done.
// Words appear the cycle after start/transfer; wr_data holds while wr_waitrequest=1; WAIT_DONE times out after TIMEOUT_CYCLES.
module aes_enc_word_loader
  import aes_loader_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] MAGIC          = 8'hA5
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  start,
  input  logic [255:0]          key,
  input  logic [127:0]          plaintext,
  aes_enc_word_loader_if.master wr,
  input  logic                  core_done,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            tag
);

  localparam logic [1:0] IDLE      = ST_IDLE;
  localparam logic [1:0] SEND      = ST_SEND;
  localparam logic [1:0] WAIT_DONE = ST_WAIT_DONE;

  localparam int            TW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state;
  logic [2:0]        idx;
  logic [TW-1:0]     timer;
  logic [255:0]      key_q;
  logic [127:0]      pt_q;

  logic              accept;
  logic              xfer;
  logic [2:0]        mux_idx;
  logic [7:0]        mux_tag;
  logic [WORD_W-1:0] mux_word;

  // The done cycle is already IDLE, but the job has only just ended there, so start is refused.
  assign accept = (state == IDLE) && start && !done;
  assign xfer   = (state == SEND) && wr.wr_valid && !wr.wr_waitrequest;

  // The mux looks one word ahead so wr_data can be a register loaded on start/transfer.
  always_comb begin
    mux_idx = idx + 3'd1;
    mux_tag = tag;
    if (accept) begin
      mux_idx = IDX_HDR;
      mux_tag = tag + 8'd1;
    end
  end

  aes_loader_word_mux #(
    .MAGIC (MAGIC)
  ) u_word_mux (
    .idx       (mux_idx),
    .key       (key_q),
    .plaintext (pt_q),
    .tag       (mux_tag),
    .word      (mux_word)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state       <= IDLE;
      idx         <= '0;
      timer       <= '0;
      key_q       <= '0;
      pt_q        <= '0;
      wr.wr_valid <= 1'b0;
      wr.wr_data  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      tag         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            key_q       <= key;
            pt_q        <= plaintext;
            tag         <= tag + 8'd1;
            err         <= 1'b0;
            idx         <= IDX_HDR;
            busy        <= 1'b1;
            wr.wr_valid <= 1'b1;
            wr.wr_data  <= mux_word;
            state       <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (idx == IDX_LAST) begin
              wr.wr_valid <= 1'b0;
              timer       <= '0;
              state       <= WAIT_DONE;
            end else begin
              idx        <= idx + 3'd1;
              wr.wr_data <= mux_word;
            end
          end
        end
        WAIT_DONE: begin
          // core_done wins over the timeout when both land on the same cycle.
          if (core_done) begin
            state <= IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (timer == T_LAST) begin
            state <= IDLE;
            done  <= 1'b1;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
